morse_interval_meter: RTL and testbench

//  Parametrised successor to the single-button tick counter in the Morse reader front end.

---
 rtl/morse_interval_meter.sv | 153 +++++++++++++++
 tb/tb_morse_interval_meter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_interval_meter.sv
// Morse key front end: synchronise and debounce the key, then time press and gap intervals in baud ticks.
// Each finished interval is offered through a one-entry valid/ready register; a full register drops new events and flags overrun.
module morse_interval_meter #(
    parameter int  CLK_F      = 25000000,
    parameter int  TICK_HZ    = 9600,
    parameter int  MAX_TICKS  = 96000,
    parameter int  DEB_CYCLES = 125000,
    localparam int W          = $clog2(MAX_TICKS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         pressed,
    output logic [W-1:0] ticks,
    output logic         ev_valid,
    input  logic         ev_ready,
    output logic         ev_kind,
    output logic [W-1:0] ev_ticks,
    output logic         ev_sat,
    output logic         overrun
);
    localparam int DIV = CLK_F / TICK_HZ;
    localparam int PW  = $clog2(DIV + 1);
    localparam int DW  = $clog2(DEB_CYCLES + 1);
    localparam logic [W-1:0]  CNT_MAX = W'(MAX_TICKS);
    localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_TOP = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [DW-1:0] deb_q, deb_d;
    logic          pressed_q, pressed_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic          flip, tick;
    logic          emit, emit_kind;
    logic          ev_valid_q, ev_valid_d, ev_kind_q, ev_kind_d, ev_sat_q, ev_sat_d;
    logic [W-1:0]  ev_ticks_q, ev_ticks_d;
    logic          ovr_q, ovr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= '0;
            pressed_q  <= 1'b0;
            pre_q      <= '0;
            cnt_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_kind_q  <= 1'b0;
            ev_ticks_q <= '0;
            ev_sat_q   <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= start;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            pressed_q  <= pressed_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            ev_valid_q <= ev_valid_d;
            ev_kind_q  <= ev_kind_d;
            ev_ticks_q <= ev_ticks_d;
            ev_sat_q   <= ev_sat_d;
            ovr_q      <= ovr_d;
        end
    end

    // Same disagreement run length for both directions keeps rise and fall latency equal.
    always_comb begin
        deb_d = '0;
        flip  = 1'b0;
        if (sync2_q != pressed_q) begin
            if (deb_q == DEB_TOP) flip = 1'b1;
            else                  deb_d = deb_q + 1'b1;
        end
    end

    assign pressed_d = pressed_q ^ flip;
    assign tick      = (pre_q == PRE_TOP);
    assign pre_d     = (flip || tick) ? '0 : pre_q + 1'b1;
    // A tick landing on the edge cycle still belongs to the closing interval, so k*DIV cycles reads k.
    assign cnt_inc   = (tick && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        emit      = 1'b0;
        emit_kind = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (flip) state_d = PRESS;
            end
            PRESS: begin
                if (flip) begin
                    emit    = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (flip) begin
                    emit      = 1'b1;
                    emit_kind = 1'b1;
                    cnt_d     = '0;
                    state_d   = PRESS;
                end else if (cnt_inc == CNT_MAX) begin
                    emit      = 1'b1;
                    emit_kind = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_kind_d  = ev_kind_q;
        ev_ticks_d = ev_ticks_q;
        ev_sat_d   = ev_sat_q;
        ovr_d      = ovr_q;
        if (emit) begin
            if (!ev_valid_q || ev_ready) begin
                ev_valid_d = 1'b1;
                ev_kind_d  = emit_kind;
                ev_ticks_d = cnt_inc;
                ev_sat_d   = (cnt_inc == CNT_MAX);
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    assign pressed  = pressed_q;
    assign ticks    = cnt_q;
    assign ev_valid = ev_valid_q;
    assign ev_kind  = ev_kind_q;
    assign ev_ticks = ev_ticks_q;
    assign ev_sat   = ev_sat_q;
    assign overrun  = ovr_q;
endmodule

// File: tb/tb_morse_interval_meter.sv
// Bench for morse_interval_meter: interval model driven by debounced-edge timestamps, plus directed literal checks.
module tb_morse_interval_meter;
    localparam int DIV  = 10;
    localparam int MAXT = 50;
    localparam int DEB  = 4;
    localparam int W    = $clog2(MAXT + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         ev_ready = 1'b1;
    logic         pressed, ev_valid, ev_kind, ev_sat, overrun;
    logic [W-1:0] ticks, ev_ticks;

    morse_interval_meter #(
        .CLK_F(100), .TICK_HZ(10), .MAX_TICKS(MAXT), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pressed(pressed), .ticks(ticks),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind),
        .ev_ticks(ev_ticks), .ev_sat(ev_sat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    bit chk_en = 1'b0;

    task automatic check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", nm, act, exp, n);
        end
    endtask

    // Model state: key history, debounce run, phase and the timestamp of the last debounced edge.
    int p1, p2, run, m_pressed, phase, last_edge, exp_ticks;
    int m_valid, m_kind, m_tk, m_sat, m_ovr;

    always @(posedge clk) begin
        int synced, el, e_k;
        bit flip, emit, take;
        n = n + 1;
        if (rst) begin
            p1 = 0; p2 = 0; run = 0; m_pressed = 0; phase = 0; last_edge = n; exp_ticks = 0;
            m_valid = 0; m_kind = 0; m_tk = 0; m_sat = 0; m_ovr = 0;
            chk_en = 1'b1;
        end else begin
            synced = p2; p2 = p1; p1 = int'(start);
            flip = 1'b0;
            if (synced != m_pressed) begin
                run++;
                if (run == DEB) begin flip = 1'b1; run = 0; end
            end else run = 0;
            if (flip) m_pressed = 1 - m_pressed;
            el = (n - last_edge) / DIV;
            if (el > MAXT) el = MAXT;
            emit = 1'b0; e_k = 0;
            case (phase)
                0: if (flip) begin phase = 1; last_edge = n; end
                1: if (flip) begin emit = 1'b1; e_k = 0; phase = 2; last_edge = n; end
                default: begin
                    if (flip) begin emit = 1'b1; e_k = 1; phase = 1; last_edge = n; end
                    else if (el >= MAXT) begin emit = 1'b1; e_k = 1; phase = 0; end
                end
            endcase
            take = (m_valid == 1) && ev_ready;
            if (emit) begin
                if (m_valid == 0 || take) begin
                    m_valid = 1; m_kind = e_k; m_tk = el; m_sat = (el == MAXT) ? 1 : 0;
                end else m_ovr = 1;
            end else if (take) m_valid = 0;
            exp_ticks = (n - last_edge) / DIV;
            if (exp_ticks > MAXT) exp_ticks = MAXT;
            if (phase == 0) exp_ticks = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pressed", int'(pressed), m_pressed);
            check("ticks", int'(ticks), exp_ticks);
            check("ev_valid", int'(ev_valid), m_valid);
            check("ev_kind", int'(ev_kind), m_kind);
            check("ev_ticks", int'(ev_ticks), m_tk);
            check("ev_sat", int'(ev_sat), m_sat);
            check("overrun", int'(overrun), m_ovr);
        end
    end

    int cap_k[$], cap_t[$], cap_s[$];
    always @(negedge clk) begin
        if (chk_en && !rst && ev_valid && ev_ready) begin
            cap_k.push_back(int'(ev_kind));
            cap_t.push_back(int'(ev_ticks));
            cap_s.push_back(int'(ev_sat));
        end
    end

    task automatic cyc(int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_ev(string nm, int idx, int k, int t, int s);
        if (idx < cap_k.size()) begin
            check({nm, "_kind"}, cap_k[idx], k);
            check({nm, "_ticks"}, cap_t[idx], t);
            check({nm, "_sat"}, cap_s[idx], s);
        end else begin
            check({nm, "_present"}, cap_k.size(), idx + 1);
        end
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        check("reset_pressed", int'(pressed), 0);
        check("reset_ticks", int'(ticks), 0);
        check("reset_valid", int'(ev_valid), 0);

        // 205-cycle press, then a 73-cycle gap
        start = 1'b1;
        cyc(5);
        check("t1_pressed_pre", int'(pressed), 0);
        cyc(1);
        check("t1_pressed_rise", int'(pressed), 1);
        cyc(100);
        check("t1_ticks_live", int'(ticks), 10);
        cyc(99);
        start = 1'b0;
        cyc(73);
        start = 1'b1;
        cyc(30);
        check("t2_count", cap_k.size(), 2);
        check_ev("t1_ev", 0, 0, 20, 0);
        check_ev("t2_ev", 1, 1, 7, 0);
        check("t2_press_live", int'(ticks), 2);
        check("t2_pressed", int'(pressed), 1);

        // press totals 100 cycles, then release until the word ends
        cyc(70);
        start = 1'b0;
        cyc(600);
        check("t4_count", cap_k.size(), 4);
        check_ev("t4_press", 2, 0, 10, 0);
        check_ev("t4_gap", 3, 1, 50, 1);
        check("t4_idle_ticks", int'(ticks), 0);

        // 3-cycle glitch in idle
        start = 1'b1;
        cyc(3);
        start = 1'b0;
        cyc(20);
        check("t3_pressed", int'(pressed), 0);
        check("t3_ticks", int'(ticks), 0);
        check("t3_count", cap_k.size(), 4);

        // consumer stalled: later events are dropped
        ev_ready = 1'b0;
        start = 1'b1; cyc(100);
        start = 1'b0; cyc(100);
        start = 1'b1; cyc(100);
        start = 1'b0; cyc(20);
        check("t5_valid", int'(ev_valid), 1);
        check("t5_kind", int'(ev_kind), 0);
        check("t5_ticks", int'(ev_ticks), 10);
        check("t5_overrun", int'(overrun), 1);
        check("t5_count", cap_k.size(), 4);
        ev_ready = 1'b1;
        cyc(1);
        check("t5_valid_drop", int'(ev_valid), 0);
        check("t5_count_after", cap_k.size(), 5);
        check_ev("t5_ev", 4, 0, 10, 0);

        // reset mid-press with a gap event pending
        ev_ready = 1'b0;
        start = 1'b1;
        cyc(30);
        check("t6_pending", int'(ev_valid), 1);
        check("t6_pending_kind", int'(ev_kind), 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("t6_rst_pressed", int'(pressed), 0);
        check("t6_rst_valid", int'(ev_valid), 0);
        check("t6_rst_ticks", int'(ev_ticks), 0);
        check("t6_rst_overrun", int'(overrun), 0);
        cyc(5);
        check("t6_pressed_pre", int'(pressed), 0);
        cyc(1);
        check("t6_pressed_rise", int'(pressed), 1);

        start = 1'b0;
        ev_ready = 1'b1;
        cyc(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
